px_fpn_correct: RTL and testbench
=================================

Name: px_fpn_correct

Overview:
- Fixed-pattern-noise (FPN) correction stage between the stonyman sequencer pixel output and the per-camera fifo_px write port; one instance per camera channel.
- Holds a dark-frame calibration image in internal RAM, one entry per pixel.
- Mode 0 (correct): each incoming pixel has its calibration value subtracted, with saturation, and is forwarded to the FIFO.
- Mode 1 (capture): the next full frame is stored as the new calibration image and nothing is forwarded.

Parameters:
- PW, 8, pixel width in bits; matches the ADC dataout width.
- NPIX, 12544, pixels per frame (112x112 stonyman array).
- AW, 14, calibration RAM address width; requires 2^AW >= NPIX.

Ports:
- clk  in  1  system clock; same clock as stonyman and fifo_px.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at frame start (driven by START_CAPTURE); resets the pixel index.
- cal_capture  in  1  level sampled at frame_start: 1 = next frame is captured into the calibration RAM.
- px_in  in  PW  raw pixel from the sequencer.
- px_in_valid  in  1  pixel strobe (sequencer writeEnable).
- px_out  out  PW  corrected pixel, to fifo_px DATA.
- px_out_valid  out  1  write strobe, to fifo_px WE.
- cal_busy  out  1  high while a capture frame is in progress.
- cal_valid  out  1  high once a complete calibration frame has been stored.
- frame_err  out  1  sticky flag: more than NPIX pixels arrived in one frame; cleared by frame_start.

Behaviour:
- Reset values: px_out=0, px_out_valid=0, cal_busy=0, cal_valid=0, frame_err=0. Pixel index=0, state=IDLE. RAM contents are not cleared.
- With cal_valid=0, correction uses an implicit calibration of 0, so pixels pass through unchanged.
- States: IDLE, CORRECT, CAPTURE.
  - IDLE: frame_start with cal_capture=1 goes to CAPTURE; with cal_capture=0 goes to CORRECT.
  - CORRECT / CAPTURE: leave when index reaches NPIX and return to IDLE. A frame_start in any state restarts the frame, resets the index to 0, re-samples cal_capture and clears frame_err.
- Pixel index:
  - Increments by 1 on each accepted px_in_valid.
  - A px_in_valid when index==NPIX is dropped and sets frame_err.
  - A px_in_valid in IDLE with no active frame is dropped and sets frame_err.
  - The index never wraps.
- CORRECT pipeline, fixed latency of 2 cycles from px_in_valid to px_out_valid:
  - Stage 1: RAM read at index; px_in registered.
  - Stage 2: px_out = (px_in >= cal) ? px_in - cal : 0, in unsigned PW-bit arithmetic.
  - px_out_valid is a single-cycle pulse per accepted pixel.
  - Back-to-back strokes at full rate are supported.
- CAPTURE:
  - Each accepted pixel is written to RAM[index]; px_out_valid stays 0.
  - cal_busy is high from the cycle after frame_start through the cycle the NPIX-th pixel is written.
  - cal_valid is cleared on entry to CAPTURE and set in the cycle after the last pixel is written.
  - An aborted capture (frame_start before NPIX pixels) leaves cal_valid=0.
- Corrected pixels still in the pipeline when frame_start arrives complete normally (2 cycles) and are not flushed.
- A read and write to the same address in the same cycle cannot occur, because mode is fixed per frame.
- Reset mid-frame:
  - Pipeline valids are cleared immediately.
  - cal_valid returns to 0; the RAM may hold a partial image and is ignored until the next complete capture.

Optional Feature:
- Macro: PX_FPN_OFFSET_EN.
- When defined:
  - Adds input port offset (in, PW) and a stage-3 register.
  - px_out = min(corrected + offset, 2^PW-1), with saturating add.
  - Latency becomes 3 cycles.
  - In pass-through (cal_valid=0) the offset is still applied.
- When undefined: no offset port, latency is 2 cycles, behaviour as above.

Test Plan:
- Reset, cal_valid=0, frame_start with cal_capture=0, pixels 0x10,0x20,0x30 -> px_out 0x10,0x20,0x30, each valid exactly 2 cycles after its input.
- Capture frame of NPIX pixels all 0x05 (cal_capture=1) -> no px_out_valid; cal_busy high throughout; cal_valid=1 the cycle after the last pixel. Next correct frame with input 0x40 -> output 0x3B; input 0x03 -> output 0x00 (saturation).
- Capture frame aborted by frame_start after 100 pixels -> cal_valid=0. A following correct frame passes input 0x80 through as 0x80.
- Correct frame with NPIX+1 pixels -> first NPIX outputs produced, extra pixel dropped, frame_err=1; next frame_start clears frame_err to 0.
- Continuous px_in_valid every cycle over a full frame -> NPIX output pulses, none lost. Assert reset mid-frame -> px_out_valid=0 the next cycle, cal_busy=0.
- With PX_FPN_OFFSET_EN, cal=0x05, offset=0x10: input 0x40 -> 0x4B after 3 cycles; input 0xFC -> 0xFF (saturation).

Source files
------------

// File: rtl/px_fpn_correct.sv
// px_fpn_correct: per-camera fixed-pattern-noise correction between the
// stonyman sequencer pixel output and the fifo_px write port.
//
// Holds a dark-frame calibration image (one entry per pixel). A "correct"
// frame subtracts the stored value from each pixel with saturation at 0.
// A "capture" frame writes each pixel into the calibration RAM instead and
// forwards nothing.
//
// Optional build macro PX_FPN_OFFSET_EN: adds an `offset` input port that is
// added, with saturation, after the subtraction. It also adds one pipeline
// stage, so latency goes from 2 to 3 cycles.
module px_fpn_correct #(
  parameter int PW   = 8,
  parameter int NPIX = 12544,
  parameter int AW   = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          cal_capture,
  input  logic [PW-1:0] px_in,
  input  logic          px_in_valid,
`ifdef PX_FPN_OFFSET_EN
  input  logic [PW-1:0] offset,
`endif
  output logic [PW-1:0] px_out,
  output logic          px_out_valid,
  output logic          cal_busy,
  output logic          cal_valid,
  output logic          frame_err
);

`ifdef PX_FPN_OFFSET_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  // The index must be able to hold NPIX itself, which marks a full frame.
  localparam logic [AW:0] IDX_END = (AW+1)'(NPIX);

  typedef enum logic [1:0] {S_IDLE, S_CORRECT, S_CAPTURE} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     idx_q;
  logic            cal_valid_q;
  logic            frame_err_q;
  logic            accept, last_px, wr_en, rd_en;

  logic [PW-1:0]   mem [0:(1<<AW)-1];
  logic [PW-1:0]   cal_rd_q;
  logic [PW-1:0]   px1_q;
  logic            use_cal_q;
  logic [LAT-1:0]  vld_q;
  logic [PW-1:0]   cal_eff, corr;
  logic [PW-1:0]   px_out_q;

  // A pixel is accepted only inside an open frame that is not yet full.
  // Any pixel that coincides with frame_start is ignored, because the
  // restart takes priority.
  assign accept  = px_in_valid && !frame_start && (state_q != S_IDLE) && (idx_q != IDX_END);
  assign last_px = accept && (idx_q == IDX_END - 1'b1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: frame_start always restarts. Otherwise the last pixel closes the frame.
  always_comb begin
    state_d = state_q;
    if (frame_start)  state_d = cal_capture ? S_CAPTURE : S_CORRECT;
    else if (last_px) state_d = S_IDLE;
  end

  // Outputs decoded from state.
  always_comb begin
    cal_busy = (state_q == S_CAPTURE);
    wr_en    = accept && (state_q == S_CAPTURE);
    rd_en    = accept && (state_q == S_CORRECT);
  end

  // Pixel index, sticky overrun flag and calibration-valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      cal_valid_q <= 1'b0;
    end else if (frame_start) begin
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      if (cal_capture) cal_valid_q <= 1'b0;
    end else begin
      if (accept)                      idx_q       <= idx_q + 1'b1;
      if (px_in_valid && !accept)      frame_err_q <= 1'b1;
      if (last_px && state_q == S_CAPTURE) cal_valid_q <= 1'b1;
    end
  end

  // Calibration RAM. It uses a synchronous read and is not reset.
  // A read and a write never target the same pixel in one cycle, because
  // the mode is fixed for the whole frame.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx_q[AW-1:0]] <= px_in;
    cal_rd_q <= mem[idx_q[AW-1:0]];
  end

  // Stage-1 data alongside the RAM read. These registers carry no reset,
  // since they are qualified by vld_q.
  always_ff @(posedge clk) begin
    px1_q     <= px_in;
    use_cal_q <= cal_valid_q;
  end

  // Valid shift register. Reset empties the pipeline immediately.
  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else       vld_q <= {vld_q[LAT-2:0], rd_en};
  end

  // Saturating subtract. Until a calibration has been stored, use 0 so
  // that pixels pass through unchanged.
  always_comb begin
    cal_eff = use_cal_q ? cal_rd_q : '0;
    corr    = (px1_q >= cal_eff) ? (px1_q - cal_eff) : '0;
  end

`ifdef PX_FPN_OFFSET_EN
  logic [PW-1:0] corr_q;
  logic [PW:0]   sum;

  // Stage 2: hold the corrected value ahead of the offset add.
  always_ff @(posedge clk) begin
    if (vld_q[0]) corr_q <= corr;
  end

  assign sum = {1'b0, corr_q} + {1'b0, offset};

  // Stage 3: saturating offset add into the output register.
  always_ff @(posedge clk) begin
    if (reset)         px_out_q <= '0;
    else if (vld_q[1]) px_out_q <= sum[PW] ? {PW{1'b1}} : sum[PW-1:0];
  end
`else
  // Stage 2: corrected value into the output register.
  always_ff @(posedge clk) begin
    if (reset)         px_out_q <= '0;
    else if (vld_q[0]) px_out_q <= corr;
  end
`endif

  assign px_out       = px_out_q;
  assign px_out_valid = vld_q[LAT-1];
  assign cal_valid    = cal_valid_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_px_fpn_correct.sv
// Bench for px_fpn_correct. It runs directed frames with random pixel data.
// The expected outputs come from a frame-level model: a calibration array,
// a frame cursor, and a queue of expected output pixels, each tagged with
// the cycle in which it is due.
module tb_px_fpn_correct;
  localparam int PW   = 8;
  localparam int NPIX = 200;
  localparam int AW   = 8;
`ifdef PX_FPN_OFFSET_EN
  localparam int LAT = 3;
  localparam int OFF = 'h10;
`else
  localparam int LAT = 2;
  localparam int OFF = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, frame_start, cal_capture, px_in_valid;
  logic [PW-1:0] px_in;
  logic [PW-1:0] px_out;
  logic          px_out_valid, cal_busy, cal_valid, frame_err;
`ifdef PX_FPN_OFFSET_EN
  logic [PW-1:0] offset = PW'(OFF);
`endif

  always #5 clk = ~clk;

  px_fpn_correct #(.PW(PW), .NPIX(NPIX), .AW(AW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .cal_capture(cal_capture),
    .px_in(px_in), .px_in_valid(px_in_valid),
`ifdef PX_FPN_OFFSET_EN
    .offset(offset),
`endif
    .px_out(px_out), .px_out_valid(px_out_valid), .cal_busy(cal_busy),
    .cal_valid(cal_valid), .frame_err(frame_err)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;

  // model state
  bit            m_active, m_cap, m_calv, m_err;
  int            m_idx;
  int            m_cal [NPIX];
  int            q_due [$];
  int            q_val [$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, o, e);
    end
  endtask

  function automatic int ref_px(input int p, input int i);
    int r;
    r = p - (m_calv ? m_cal[i] : 0);
    if (r < 0) r = 0;
    r = r + OFF;
    if (r > (1 << PW) - 1) r = (1 << PW) - 1;
    return r;
  endfunction

  // Drive one cycle, advance the model, then check the outputs just after the edge.
  task automatic step(input bit r, input bit fs, input bit cap, input bit v, input int px);
    bit exp_v;
    reset = r; frame_start = fs; cal_capture = cap; px_in_valid = v; px_in = PW'(px);
    if (r) begin
      m_active = 0; m_calv = 0; m_err = 0;
      q_due.delete(); q_val.delete();
    end else if (fs) begin
      m_active = 1; m_cap = cap; m_idx = 0; m_err = 0;
      if (cap) m_calv = 0;
    end else if (v) begin
      if (m_active && m_idx < NPIX) begin
        if (m_cap) m_cal[m_idx] = px;
        else begin
          q_due.push_back(cyc + LAT);
          q_val.push_back(ref_px(px, m_idx));
        end
        m_idx++;
        if (m_idx == NPIX) begin
          m_active = 0;
          if (m_cap) m_calv = 1;
        end
      end else m_err = 1;
    end
    @(posedge clk);
    cyc++;
    #1;
    exp_v = (q_due.size() > 0) && (q_due[0] == cyc);
    chk("px_out_valid", 32'(px_out_valid), 32'(exp_v));
    if (exp_v) begin
      chk("px_out", 32'(px_out), 32'(q_val[0]));
      void'(q_due.pop_front());
      void'(q_val.pop_front());
    end
    chk("cal_busy",  32'(cal_busy),  32'(m_active && m_cap));
    chk("cal_valid", 32'(cal_valid), 32'(m_calv));
    chk("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int px);
    step(0, 0, 0, 1, px);
  endtask

  initial begin
    // reset
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk("reset_px_out", 32'(px_out), 32'h0);
    idle(2);

    // pass-through with no calibration
    step(0, 1, 0, 0, 0);
    pix('h10); idle(1); pix('h20); pix('h30);
    idle(3);

    // capture a flat dark frame of 0x05 with random gaps
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < NPIX; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      pix('h05);
    end
    idle(2);

    // correct: 0x40 -> 0x3B, 0x03 -> 0 (saturate); then an overrun pixel
    step(0, 1, 0, 0, 0);
    pix('h40); pix('h03); pix('hFC);
    for (int i = 3; i < NPIX; i++) pix(int'($urandom_range(0, 255)));
    pix('h55);
    idle(3);
    step(0, 1, 0, 0, 0);
    pix('h22);
    idle(3);

    // random calibration frame, then full-rate correct frame ended by an
    // immediate frame_start while outputs are still in flight
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < NPIX; i++) pix(int'($urandom_range(0, 255)));
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) pix(int'($urandom_range(0, 255)));
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) pix(int'($urandom_range(0, 255)));
    idle(3);

    // aborted capture leaves cal_valid low; 0x80 passes through
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 100; i++) pix(int'($urandom_range(0, 255)));
    step(0, 1, 0, 0, 0);
    pix('h80);
    for (int i = 0; i < 5; i++) pix(int'($urandom_range(0, 255)));
    idle(3);

    // reset in the middle of a full-rate correct frame
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) pix(int'($urandom_range(0, 255)));
    step(1, 0, 0, 1, 'h11);
    idle(2);

    // reset in the middle of a capture frame
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) pix(int'($urandom_range(0, 255)));
    step(1, 0, 0, 0, 0);
    idle(1);

    // a pixel with no open frame is dropped and flagged
    pix('h33);
    idle(2);
    step(0, 1, 0, 0, 0);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
